// File: rtl/msg_ctrl_pkg.sv
// rtl/msg_ctrl_pkg.sv - shared state encoding and defaults for the message sender
package msg_ctrl_pkg;

  // Sequencer states: fetch a ROM byte, load it, wait for the UART, optionally idle in a gap
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int DEFAULT_MSG_LEN    = 14;
  localparam int DEFAULT_GAP_CYCLES = 50_000_000;

  // Counter width able to hold GAP_CYCLES-1 (never narrower than one bit)
  function automatic int gap_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - loadable down-counter with zero flag for the inter-message gap
module gap_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // Load has priority; decrement saturates at zero so a stalled caller never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  // Zero flag straight from the count register
  assign zero = (value == '0);

endmodule

// File: rtl/message_sender.sv
// rtl/message_sender.sv - streams a fixed ROM message to a UART, with optional periodic repeat
module message_sender
  import msg_ctrl_pkg::*;
#(
  parameter int MSG_LEN    = DEFAULT_MSG_LEN,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       abort,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done
);

  localparam int               GAP_W    = gap_width(GAP_CYCLES);
  localparam logic [3:0]       LAST_IDX = 4'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t             state;
  state_t             next_state;
  logic [3:0]         idx;
  logic [3:0]         idx_next;
  logic               strobe_next;
  logic               done_next;
  logic               tx_load;
  logic               gap_load;
  logic               gap_dec;
  logic [GAP_W-1:0]   gap_value;
  logic               gap_zero;

  gap_timer #(
    .WIDTH (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .value      (gap_value),
    .zero       (gap_zero)
  );

  // State and character index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
    end
  end

  // Next-state, index and strobe decisions; abort overrides everything
  always_comb begin
    next_state  = state;
    idx_next    = idx;
    strobe_next = 1'b0;
    done_next   = 1'b0;
    tx_load     = 1'b0;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
      idx_next   = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_next = 4'd0;
          if (start || repeat_en) begin
            next_state = ST_FETCH;
          end
        end
        ST_FETCH: begin
          next_state = ST_LOAD;
        end
        ST_LOAD: begin
          tx_load    = 1'b1;
          next_state = ST_SEND;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            strobe_next = 1'b1;
            if (idx == LAST_IDX) begin
              done_next = 1'b1;
              if (repeat_en) begin
                gap_load   = 1'b1;
                next_state = ST_GAP;
              end else begin
                idx_next   = 4'd0;
                next_state = ST_IDLE;
              end
            end else begin
              idx_next   = idx + 4'd1;
              next_state = ST_FETCH;
            end
          end
        end
        ST_GAP: begin
          if (!repeat_en) begin
            idx_next   = 4'd0;
            next_state = ST_IDLE;
          end else if (gap_zero) begin
            idx_next   = 4'd0;
            next_state = ST_FETCH;
          end else begin
            gap_dec = 1'b1;
          end
        end
        default: begin
          idx_next   = 4'd0;
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs: ROM address presented on entry to FETCH, byte captured in LOAD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr    <= 4'd0;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      done        <= 1'b0;
    end else begin
      new_tx_data <= strobe_next;
      done        <= done_next;
      if (tx_load) begin
        tx_data <= rom_data;
      end
      if (next_state == ST_FETCH) begin
        rom_addr <= idx_next;
      end else if (next_state == ST_IDLE) begin
        rom_addr <= 4'd0;
      end
    end
  end

  // Busy decodes straight from the state register
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_message_sender.sv
// tb/tb_message_sender.sv - self-checking bench for message_sender
module tb_message_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       repeat_en;
  logic       abort;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] rom [16];
  logic [7:0] exp_msg [14] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57,
                               8'h4F, 8'h52, 8'h4C, 8'h44, 8'h21, 8'h0A, 8'h0D};

  int         cyc = 0;
  int         strobe_cyc[$];
  logic [7:0] strobe_byte[$];
  int         done_cyc[$];
  int         bp_viol   = 0;
  int         addr_viol = 0;
  int         bp_left   = 0;
  bit         bp_en     = 1'b0;

  always #5 clk = ~clk;

  message_sender #(
    .MSG_LEN    (14),
    .GAP_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .repeat_en   (repeat_en),
    .abort       (abort),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  // Registered character ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Edge counter, strobe/done recorder and UART busy model
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (new_tx_data) begin
      strobe_cyc.push_back(cyc);
      strobe_byte.push_back(tx_data);
      if (tx_busy) bp_viol++;
    end
    if (done) done_cyc.push_back(cyc);
    if (rom_addr > 4'd13) addr_viol++;
    if (bp_left > 0) begin
      tx_busy = 1'b1;
      bp_left--;
    end else begin
      tx_busy = 1'b0;
    end
    if (new_tx_data && bp_en) bp_left = 10;
  end

  task automatic clear_mon();
    strobe_cyc.delete();
    strobe_byte.delete();
    done_cyc.delete();
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
    wait_neg(3);
    compared++; if (rom_addr !== 4'd0) begin mismatched++; $display("FAIL reset_rom_addr got %0h want 0", rom_addr); end
    compared++; if (tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data got %0h want 00", tx_data); end
    compared++; if (new_tx_data !== 1'b0) begin mismatched++; $display("FAIL reset_strobe got %b want 0", new_tx_data); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    clear_mon();
    wait_neg(5);
    compared++; if (strobe_cyc.size() != 0) begin mismatched++; $display("FAIL idle_no_strobe got %0d want 0", strobe_cyc.size()); end
  endtask

  task automatic test_single_message(input string tag);
    int c0;
    logic b41, b43;
    b41 = 1'bx; b43 = 1'bx;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == c0 + 41) b41 = busy;
      if (cyc == c0 + 43) b43 = busy;
    end
    compared++; if (strobe_cyc.size() != 14) begin mismatched++; $display("FAIL %s strobe_count got %0d want 14", tag, strobe_cyc.size()); end
    for (int k = 0; k < 14 && k < strobe_cyc.size(); k++) begin
      compared++;
      if (strobe_cyc[k] != c0 + 3 * (k + 1) || strobe_byte[k] !== exp_msg[k]) begin
        mismatched++;
        $display("FAIL %s strobe%0d got cyc %0d byte %0h want cyc %0d byte %0h", tag, k,
                 strobe_cyc[k] - c0, strobe_byte[k], 3 * (k + 1), exp_msg[k]);
      end
    end
    compared++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 42) begin mismatched++; $display("FAIL %s done got count %0d want one pulse at 42", tag, done_cyc.size()); end
    compared++; if (b41 !== 1'b1) begin mismatched++; $display("FAIL %s busy_41 got %b want 1", tag, b41); end
    compared++; if (b43 !== 1'b0) begin mismatched++; $display("FAIL %s busy_43 got %b want 0", tag, b43); end
  endtask

  task automatic test_backpressure();
    int c0, v0, n;
    v0 = bp_viol;
    bp_en = 1'b1;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (strobe_cyc.size() < 14 && n < 400) begin
      @(negedge clk);
      n++;
    end
    bp_en = 1'b0;
    wait_neg(20);
    compared++; if (strobe_cyc.size() != 14) begin mismatched++; $display("FAIL bp_strobe_count got %0d want 14", strobe_cyc.size()); end
    for (int k = 0; k < 14 && k < strobe_cyc.size(); k++) begin
      compared++;
      if (strobe_byte[k] !== exp_msg[k] || strobe_cyc[k] != c0 + 3 + 12 * k) begin
        mismatched++;
        $display("FAIL bp_strobe%0d got cyc %0d byte %0h want cyc %0d byte %0h", k,
                 strobe_cyc[k] - c0, strobe_byte[k], 3 + 12 * k, exp_msg[k]);
      end
    end
    compared++; if (bp_viol != v0) begin mismatched++; $display("FAIL bp_strobe_while_busy got %0d want %0d", bp_viol, v0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_end_busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int c1;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_neg(15);
    compared++; if (strobe_cyc.size() != 5) begin mismatched++; $display("FAIL abort_pre_count got %0d want 5", strobe_cyc.size()); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy got %b want 0", busy); end
    wait_neg(40);
    compared++; if (strobe_cyc.size() != 5) begin mismatched++; $display("FAIL abort_post_count got %0d want 5", strobe_cyc.size()); end
    compared++; if (done_cyc.size() != 0) begin mismatched++; $display("FAIL abort_done got %0d want 0", done_cyc.size()); end
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    c1 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_neg(5);
    compared++;
    if (strobe_cyc.size() != 1 || strobe_cyc[0] != c1 + 3 || strobe_byte[0] !== 8'h48) begin
      mismatched++;
      $display("FAIL abort_restart got count %0d want first byte 48 at cycle 3", strobe_cyc.size());
    end
    wait_neg(45);
  endtask

  task automatic test_repeat();
    int c0, n;
    logic b_gap, b_after;
    clear_mon();
    @(negedge clk);
    repeat_en = 1'b1;
    c0 = cyc + 1;
    n = 0;
    while (cyc != c0 + 109 && n < 200) begin
      @(negedge clk);
      n++;
    end
    b_gap = busy;
    repeat_en = 1'b0;
    @(negedge clk);
    b_after = busy;
    wait_neg(40);
    compared++; if (strobe_cyc.size() != 28) begin mismatched++; $display("FAIL rep_strobe_count got %0d want 28", strobe_cyc.size()); end
    if (strobe_cyc.size() >= 28) begin
      compared++; if (strobe_cyc[14] - strobe_cyc[13] != 23) begin mismatched++; $display("FAIL rep_gap got %0d want 23", strobe_cyc[14] - strobe_cyc[13]); end
      compared++; if (strobe_byte[14] !== 8'h48 || strobe_byte[27] !== 8'h0D) begin mismatched++; $display("FAIL rep_bytes got %0h/%0h want 48/0d", strobe_byte[14], strobe_byte[27]); end
      compared++; if (strobe_cyc[27] != c0 + 104) begin mismatched++; $display("FAIL rep_last got %0d want 104", strobe_cyc[27] - c0); end
    end
    compared++; if (done_cyc.size() != 2) begin mismatched++; $display("FAIL rep_done got %0d want 2", done_cyc.size()); end
    compared++; if (b_gap !== 1'b1) begin mismatched++; $display("FAIL rep_busy_in_gap got %b want 1", b_gap); end
    compared++; if (b_after !== 1'b0) begin mismatched++; $display("FAIL rep_drop_idle got %b want 0", b_after); end
  endtask

  task automatic test_start_storm();
    int n;
    bit seen;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 80) begin
      @(negedge clk);
      n++;
      if (done_cyc.size() > 0) seen = 1'b1;
    end
    start = 1'b0;
    compared++; if (!seen) begin mismatched++; $display("FAIL storm_timeout got no done want done within 80 cycles"); end
    wait_neg(60);
    compared++; if (strobe_cyc.size() != 14) begin mismatched++; $display("FAIL storm_strobes got %0d want 14", strobe_cyc.size()); end
    compared++; if (done_cyc.size() != 1) begin mismatched++; $display("FAIL storm_done got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int gap;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 5;
    wait_neg(gap);
    compared++; if (tx_data !== 8'h45) begin mismatched++; $display("FAIL rstmid_pre_tx got %0h want 45", tx_data); end
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (tx_data !== 8'h00 || rom_addr !== 4'd0 || new_tx_data !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_clear got tx %0h addr %0h strobe %b busy %b done %b want all zero",
               tx_data, rom_addr, new_tx_data, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (new_tx_data !== 1'b0) begin mismatched++; $display("FAIL rstmid_after got %b want 0", new_tx_data); end
    wait_neg(10);
    compared++; if (strobe_cyc.size() != 1) begin mismatched++; $display("FAIL rstmid_count got %0d want 1", strobe_cyc.size()); end
    test_single_message("recovery");
  endtask

  task automatic test_random_starts();
    int d;
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 7);
      wait_neg(d);
      test_single_message("random");
    end
  endtask

  initial begin
    string s;
    s = "HELLO WORLD!\n\r";
    for (int i = 0; i < 16; i++) rom[i] = (i < 14) ? s[i] : 8'h00;
    test_reset();
    test_single_message("single");
    test_backpressure();
    test_abort();
    test_repeat();
    test_start_storm();
    test_reset_mid();
    test_random_starts();
    compared++; if (addr_viol != 0) begin mismatched++; $display("FAIL rom_addr_range got %0d want 0", addr_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
